// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  localparam logic [3:0] NIBBLE_ADJ_THRESH = 4'd5;
  localparam logic [3:0] NIBBLE_ADJ_ADD    = 4'd3;

  // Number of decimal digits needed to show 2^w-1.
  function automatic int min_digits(input int w);
    longint v;
    int     d;
    v = 64'sd1;
    v = (v << w) - 64'sd1;
    d = 0;
    while (v != 64'sd0) begin
      v = v / 64'sd10;
      d = d + 1;
    end
    if (d == 0) begin
      d = 1;
    end
    return d;
  endfunction

  // 4-bit add-3 correction, wraps without carry out.
  function automatic logic [3:0] nibble_adj(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= NIBBLE_ADJ_THRESH) begin
      res = nib + NIBBLE_ADJ_ADD;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// One BCD digit correction stage: adds 3 to a nibble that is 5 or more.
module bcd_nibble_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  // Pure combinational correction.
  always_comb begin
    adjusted = nibble_adj(nibble);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Optional leading-zero blanking mask built only when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int TOT_W = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if ((WIDTH < 4) || (WIDTH > 32)) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH must be in 4..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  b2b_state_t          state_r;
  logic [CNT_W-1:0]    count_r;
  logic [TOT_W-1:0]    sreg_r;
  logic [TOT_W-1:0]    adj_s;
  logic [TOT_W-1:0]    shifted_s;
  logic [BCD_W-1:0]    bcd_r;
  logic                out_valid_r;
  logic                accept_s;
  logic                last_shift_s;

  // Add-3 touches only the BCD field; the binary field passes straight through.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .nibble   (sreg_r[WIDTH + 4*g +: 4]),
      .adjusted (adj_s[WIDTH + 4*g +: 4])
    );
  end
  assign adj_s[WIDTH-1:0] = sreg_r[WIDTH-1:0];
  assign shifted_s        = {adj_s[TOT_W-2:0], 1'b0};

  assign in_ready     = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s     = in_valid && in_ready;
  assign last_shift_s = (state_r == SHIFT) && (count_r == LAST_CNT);
  assign out_valid    = out_valid_r;
  assign bcd          = bcd_r;

  // Conversion FSM with shift register, bit counter and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= {CNT_W{1'b0}};
      sreg_r      <= {TOT_W{1'b0}};
      bcd_r       <= {BCD_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sreg_r  <= {{BCD_W{1'b0}}, bin};
            count_r <= {CNT_W{1'b0}};
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          sreg_r  <= shifted_s;
          count_r <= count_r + CNT_W'(1);
          if (count_r == LAST_CNT) begin
            bcd_r       <= shifted_s[TOT_W-1 -: BCD_W];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (in_valid) begin
              sreg_r  <= {{BCD_W{1'b0}}, bin};
              count_r <= {CNT_W{1'b0}};
              state_r <= SHIFT;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next_s;
  logic [DIGITS-1:0] blank_r;

  // Digit i blanks when it and every digit above it are zero; units never blank.
  always_comb begin
    logic hi_zero;
    hi_zero      = 1'b1;
    blank_next_s = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero         = hi_zero && (shifted_s[WIDTH + 4*i +: 4] == 4'd0);
      blank_next_s[i] = hi_zero;
    end
  end

  // Mask is captured on the same edge as the BCD result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_r <= {DIGITS{1'b0}};
    end else if (last_shift_s) begin
      blank_r <= blank_next_s;
    end else begin
      blank_r <= blank_r;
    end
  end

  assign blank = blank_r;
`else
  assign blank = {DIGITS{1'b0}};
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: an 8-bit/3-digit and a 16-bit/5-digit converter against a div/mod cycle model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [7:0]  a_bin = 8'd0;
  logic [11:0] a_bcd;
  logic [2:0]  a_blank;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [15:0] b_bin = 16'd0;
  logic [19:0] b_bcd;
  logic [4:0]  b_blank;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .bin(a_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .bcd(a_bcd), .blank(a_blank)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(b_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .bcd(b_bcd), .blank(b_blank)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by repeated div/mod, units in [3:0].
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = 20'd0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digit i is blank when the value is below 10^i (i >= 1).
  function automatic logic [4:0] blank_of(input int v);
    logic [4:0] m;
    int p;
    m = 5'd0;
    p = 10;
`ifdef BIN2BCD_BLANK_EN
    for (int i = 1; i < 5; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
`endif
    return m;
  endfunction

  // Cycle model: accept -> result visible after latency edges, held until taken.
  int ma_pend = 0, ma_val = 0;
  bit ma_valid = 1'b0;
  int mb_pend = 0, mb_val = 0;
  bit mb_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ma_pend <= 0; ma_valid <= 1'b0;
    end else if (ma_valid) begin
      if (a_out_ready) begin
        ma_valid <= 1'b0;
        if (a_in_valid) begin ma_val <= int'(a_bin); ma_pend <= 8; end
      end
    end else if (ma_pend > 0) begin
      ma_pend <= ma_pend - 1;
      if (ma_pend == 1) ma_valid <= 1'b1;
    end else if (a_in_valid) begin
      ma_val <= int'(a_bin); ma_pend <= 8;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mb_pend <= 0; mb_valid <= 1'b0;
    end else if (mb_valid) begin
      if (b_out_ready) begin
        mb_valid <= 1'b0;
        if (b_in_valid) begin mb_val <= int'(b_bin); mb_pend <= 16; end
      end
    end else if (mb_pend > 0) begin
      mb_pend <= mb_pend - 1;
      if (mb_pend == 1) mb_valid <= 1'b1;
    end else if (b_in_valid) begin
      mb_val <= int'(b_bin); mb_pend <= 16;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_out_valid", 32'(a_out_valid), 32'(ma_valid));
      chk("a_in_ready", 32'(a_in_ready), 32'((!ma_valid && ma_pend == 0) || (ma_valid && a_out_ready)));
      if (ma_valid) begin
        chk("a_bcd", 32'(a_bcd), 32'(12'(to_bcd(ma_val))));
        chk("a_blank", 32'(a_blank), 32'(3'(blank_of(ma_val))));
      end
      chk("b_out_valid", 32'(b_out_valid), 32'(mb_valid));
      chk("b_in_ready", 32'(b_in_ready), 32'((!mb_valid && mb_pend == 0) || (mb_valid && b_out_ready)));
      if (mb_valid) begin
        chk("b_bcd", 32'(b_bcd), 32'(to_bcd(mb_val)));
        chk("b_blank", 32'(b_blank), 32'(blank_of(mb_val)));
      end
    end
  end

  task automatic a_conv(input logic [7:0] v, input bit hold_valid, output int lat);
    a_bin = v;
    a_in_valid = 1'b1;
    for (int i = 0; i < 40 && !a_in_ready; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    if (!hold_valid) a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic b_conv(input logic [15:0] v, output int lat);
    b_bin = v;
    b_in_valid = 1'b1;
    for (int i = 0; i < 40 && !b_in_ready; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    int lat, n;
    bit seen;
    logic [15:0] vecs [0:10];

    // Pin the model helpers to hand-computed digits.
    chk("model_255", 32'(to_bcd(255)), 32'h00255);
    chk("model_65535", 32'(to_bcd(65535)), 32'h65535);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_out_valid", 32'(a_out_valid), 32'd0);
    chk("reset_in_ready", 32'(a_in_ready), 32'd1);
    chk("reset_bcd", 32'(a_bcd), 32'h000);
    chk("reset_blank", 32'(a_blank), 32'd0);

    // 255 -> 255, latency 8
    a_out_ready = 1'b1;
    a_conv(8'd255, 1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd8);
    chk("t1_bcd", 32'(a_bcd), 32'h255);
    @(posedge clk); #1;

    // zero
    a_conv(8'd0, 1'b0, lat);
    chk("t2_bcd", 32'(a_bcd), 32'h000);
`ifdef BIN2BCD_BLANK_EN
    chk("t2_blank", 32'(a_blank), 32'b110);
`else
    chk("t2_blank", 32'(a_blank), 32'b000);
`endif
    @(posedge clk); #1;

    // consumer stalls for 5 cycles
    a_out_ready = 1'b0;
    a_conv(8'd47, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      chk("t3_bcd_hold", 32'(a_bcd), 32'h047);
      chk("t3_in_ready", 32'(a_in_ready), 32'd0);
      chk("t3_valid_hold", 32'(a_out_valid), 32'd1);
`ifdef BIN2BCD_BLANK_EN
      chk("t3_blank", 32'(a_blank), 32'b100);
`else
      chk("t3_blank", 32'(a_blank), 32'b000);
`endif
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_released", 32'(a_out_valid), 32'd0);

    // back-to-back 99 then 100
    a_conv(8'd99, 1'b1, lat);
    a_bin = 8'd100;
    chk("t4_bcd_99", 32'(a_bcd), 32'h099);
    chk("t4_ready_in_done", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n = 1;
    while (!a_out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("t4_spacing", 32'(n), 32'd9);
    chk("t4_bcd_100", 32'(a_bcd), 32'h100);
    @(posedge clk); #1;

    // reset 4 cycles into converting 200
    a_bin = 8'd200;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_out_valid", 32'(a_out_valid), 32'd0);
    chk("t5_in_ready", 32'(a_in_ready), 32'd1);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (a_out_valid) seen = 1'b1; end
    chk("t5_no_output", 32'(seen), 32'd0);
    a_conv(8'd13, 1'b0, lat);
    chk("t5_bcd_13", 32'(a_bcd), 32'h013);
    @(posedge clk); #1;

    // 16-bit corners and random values
    vecs[0] = 16'd0; vecs[1] = 16'd1; vecs[2] = 16'd9999; vecs[3] = 16'd10000; vecs[4] = 16'd65535;
    for (int i = 5; i < 11; i++) vecs[i] = 16'($urandom_range(65535));
    for (int i = 0; i < 11; i++) begin
      b_conv(vecs[i], lat);
      chk("t6_latency", 32'(lat), 32'd16);
      if (vecs[i] == 16'd65535) chk("t6_bcd_65535", 32'(b_bcd), 32'h65535);
      if (vecs[i] == 16'd10000) chk("t6_bcd_10000", 32'(b_bcd), 32'h10000);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
